// File: rtl/cpu_pio_pkg.sv
// Shared constants for the Avalon-MM input PIO (cpu_pio_inputs_irq).
// Register offsets and edge-capture mode encodings.
package cpu_pio_pkg;

    typedef enum logic [1:0] {
        PIO_OFS_DATA = 2'd0,
        PIO_OFS_RSVD = 2'd1,
        PIO_OFS_MASK = 2'd2,
        PIO_OFS_EDGE = 2'd3
    } pio_ofs_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/cpu_pio_input_cond.sv
// One-bit input conditioner: SYNC_STAGES-flop synchroniser, optionally followed
// by a debouncer when CPU_PIO_DEBOUNCE_EN is defined.
module cpu_pio_input_cond #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 2) begin : g_param_check
        $error("cpu_pio_input_cond: SYNC_STAGES and DEBOUNCE_CYC must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CPU_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_q, cond_d;

    // Count consecutive cycles where the synchronised bit disagrees with cond;
    // the DEBOUNCE_CYC-th disagreeing cycle commits the new value, so the
    // counter never needs to hold DEBOUNCE_CYC itself.
    always_comb begin
        cnt_d  = '0;
        cond_d = cond_q;
        if (sync_out != cond_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                cond_d = sync_out;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            cond_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
        end
    end

    assign dout = cond_q;
`else
    assign dout = sync_out;
`endif

endmodule

// File: rtl/cpu_pio_inputs_irq.sv
// Avalon-MM input PIO with per-bit edge capture and masked level IRQ.
// Optional input debouncing is enabled by defining CPU_PIO_DEBOUNCE_EN.
module cpu_pio_inputs_irq
    import cpu_pio_pkg::*;
#(
    parameter int unsigned WIDTH        = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned EDGE_TYPE    = 0,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > EDGE_ANY) begin : g_param_check
        $error("cpu_pio_inputs_irq: WIDTH must be 1..32 and EDGE_TYPE 0..2");
    end

    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] evt;
    logic             wr_en;
    logic             unused_wd;

    assign unused_wd = &{1'b0, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cond
        cpu_pio_input_cond #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_cond (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .dout    (cond[i])
        );
    end

    // Edge detect, register writes, read mux and irq next-state.
    always_comb begin
        prev_d = cond;
        if (EDGE_TYPE == EDGE_FALL) begin
            evt = ~cond & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            evt = cond ^ prev_q;
        end else begin
            evt = cond & ~prev_q;
        end

        wr_en  = chipselect & ~write_n;
        mask_d = mask_q;
        if (wr_en && address == PIO_OFS_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end

        // Clear first, then OR in events so a same-cycle event wins.
        edgecap_d = edgecap_q;
        if (wr_en && address == PIO_OFS_EDGE) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | evt;

        readdata_d = '0;
        case (pio_ofs_e'(address))
            PIO_OFS_DATA: readdata_d[WIDTH-1:0] = cond;
            PIO_OFS_MASK: readdata_d[WIDTH-1:0] = mask_q;
            PIO_OFS_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d            = '0;
        endcase

        irq_d = |(edgecap_q & mask_q);
    end

    // Register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_cpu_pio_inputs_irq.sv
// Self-checking bench for cpu_pio_inputs_irq: three instances share the bus
// and inputs, one per EDGE_TYPE (rise, fall, any).
module tb_cpu_pio_inputs_irq;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef CPU_PIO_DEBOUNCE_EN
    localparam int LAT = SYNC + DEB;
`else
    localparam int LAT = SYNC;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] r0, r1, r2;
        logic        i0, i1, i2;
    } vec_t;

    vec_t tbl [15];

    cpu_pio_inputs_irq #(.WIDTH(2), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYC(DEB)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    cpu_pio_inputs_irq #(.WIDTH(2), .SYNC_STAGES(SYNC), .EDGE_TYPE(1), .DEBOUNCE_CYC(DEB)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    cpu_pio_inputs_irq #(.WIDTH(2), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYC(DEB)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        write_n    = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic x0, input logic x1, input logic x2);
        chk({nm, " rd_rise"}, rd0, e0);
        chk({nm, " rd_fall"}, rd1, e1);
        chk({nm, " rd_any"},  rd2, e2);
        chk({nm, " irq_rise"}, {31'b0, irq0}, {31'b0, x0});
        chk({nm, " irq_fall"}, {31'b0, irq1}, {31'b0, x1});
        chk({nm, " irq_any"},  {31'b0, irq2}, {31'b0, x2});
    endtask

    initial begin
        // Register-access vectors, in_port held at 2'b11, mask starts at 0,
        // EDGECAP starts at rise=3 fall=0 any=3.
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h0000_00FF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd2, 32'h3,         32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'd2, 32'd2, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'd3, 32'h1,         32'd3, 32'd0, 32'd3, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2'd3, 32'h0,         32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'd3, 32'h2,         32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'd3, 32'h2,         32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'd3, 32'h0,         32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 2'd2, 32'h1,         32'd2, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0};

        // Reset with inputs high; a high input out of reset is a rising edge.
        reset_n    = 1'b0;
        in_port    = 2'b11;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        run(3);
        chk3("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        run(LAT);
        chk3("p1 pre", 0, 0, 0, 0, 0, 0);
        tick();
        chk3("p1 data", 3, 3, 3, 0, 0, 0);
        rd(2'd3);
        tick();
        chk3("p1 edgecap", 3, 0, 3, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            chipselect = tbl[i].cs;
            write_n    = tbl[i].wn;
            address    = tbl[i].addr;
            writedata  = tbl[i].wd;
            tick();
            chk3($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].r2,
                 tbl[i].i0, tbl[i].i1, tbl[i].i2);
        end

        // Mask = 01: capture, irq one cycle later, W1C drops irq next cycle.
        in_port = 2'b10;
        rd(2'd3);
        run(LAT + 2);
        chk3("p2 fall", 0, 1, 1, 0, 1, 1);
        wr(2'd3, 32'h1);
        tick();
        chk3("p2 clr", 0, 0, 0, 0, 0, 0);
        in_port = 2'b11;
        run(LAT + 1);
        chk3("p2 pre", 0, 0, 0, 0, 0, 0);
        tick();
        chk3("p2 cap", 1, 0, 1, 1, 0, 1);
        wr(2'd3, 32'h1);
        chk3("p2 w1c", 1, 0, 1, 1, 0, 1);
        tick();
        chk3("p2 drop", 0, 0, 0, 0, 0, 0);

        // Clear and new event in the same cycle: the event wins.
        in_port = 2'b10;
        run(LAT + 2);
        in_port = 2'b11;
        run(LAT + 2);
        in_port = 2'b10;
        run(LAT + 2);
        chk3("p3 armed", 1, 1, 1, 1, 1, 1);
        in_port = 2'b11;
        run(LAT);
        wr(2'd3, 32'h1);
        chk3("p3 same", 1, 1, 1, 1, 1, 1);
        tick();
        chk3("p3 hold", 1, 0, 1, 1, 0, 1);

        // Bit-1 edges per EDGE_TYPE; bit 1 is masked so irq stays low.
        wr(2'd3, 32'h3);
        in_port = 2'b01;
        run(LAT + 2);
        chk3("p4 fall b1", 0, 2, 2, 0, 0, 0);
        wr(2'd3, 32'h3);
        in_port = 2'b11;
        run(LAT + 2);
        chk3("p4 rise b1", 2, 0, 2, 0, 0, 0);
        wr(2'd3, 32'h3);
        in_port = 2'b01;
        run(LAT + 2);
        chk3("p4 fall2 b1", 0, 2, 2, 0, 0, 0);
        wr(2'd3, 32'h3);

`ifdef CPU_PIO_DEBOUNCE_EN
        // Short glitch is rejected; sustained level appears after full latency.
        in_port = 2'b00;
        run(LAT + 2);
        wr(2'd3, 32'h3);
        rd(2'd0);
        in_port = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("p5 glitch hi %0d", i), rd0, 32'd0);
        end
        in_port = 2'b00;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("p5 glitch lo %0d", i), rd0, 32'd0);
        end
        rd(2'd3);
        tick();
        chk3("p5 nocap", 0, 0, 0, 0, 0, 0);
        rd(2'd0);
        in_port = 2'b01;
        run(LAT);
        chk("p5 data early", rd0, 32'd0);
        tick();
        chk("p5 data", rd0, 32'd1);
`endif

        // Asynchronous reset while irq is high and EDGECAP = 3.
        wr(2'd2, 32'h3);
        in_port = 2'b11;
        run(LAT + 2);
        in_port = 2'b00;
        run(LAT + 2);
        in_port = 2'b11;
        rd(2'd3);
        run(LAT + 2);
        chk3("p6 armed", 3, 3, 3, 1, 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk3("p6 async", 0, 0, 0, 0, 0, 0);
        in_port = 2'b00;
        run(2);
        reset_n = 1'b1;
        rd(2'd2);
        tick();
        chk3("p6 mask", 0, 0, 0, 0, 0, 0);
        rd(2'd3);
        tick();
        chk3("p6 edgecap", 0, 0, 0, 0, 0, 0);
        rd(2'd1);
        tick();
        chk3("p6 rsvd", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
